// File: rtl/lzc_miao16.sv
// rtl/lzc_miao16.sv - registered 16-bit leading-zero counter (Miao nibble tree)
// Optional LZC_IN_REG_EN adds an input register stage (latency 2).
module lzc_miao16 #(
  parameter int RANGE_WIDTH = 16,
  parameter int D_SIZE      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [RANGE_WIDTH-1:0] in,
  output logic                   out_valid,
  output logic [D_SIZE-1:0]      out_z,
  output logic                   v
);

  logic [RANGE_WIDTH-1:0] stage_in;
  logic                   stage_valid;

`ifdef LZC_IN_REG_EN
  logic [RANGE_WIDTH-1:0] in_q;
  logic                   in_valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q       <= '0;
      in_valid_q <= 1'b0;
    end else begin
      in_q       <= in;
      in_valid_q <= in_valid;
    end
  end

  assign stage_in    = in_q;
  assign stage_valid = in_valid_q;
`else
  assign stage_in    = in;
  assign stage_valid = in_valid;
`endif

  // A zero nibble reports 3 so the cell stays X-free; the encoder never selects it.
  function automatic logic [1:0] nib_lz(input logic [3:0] n);
    logic [1:0] z;
    if (n[3])      z = 2'd0;
    else if (n[2]) z = 2'd1;
    else if (n[1]) z = 2'd2;
    else           z = 2'd3;
    return z;
  endfunction

  logic [3:0]        a;
  logic [1:0]        z [4];
  logic [1:0]        sel;
  logic              v_d;
  logic [D_SIZE-1:0] out_z_d;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i] = (stage_in[i*4 +: 4] == 4'd0);
      z[i] = nib_lz(stage_in[i*4 +: 4]);
    end
  end

  always_comb begin
    sel = 2'd3;
    if (!a[3])      sel = 2'd0;
    else if (!a[2]) sel = 2'd1;
    else if (!a[1]) sel = 2'd2;
    v_d     = ~(&a);
    out_z_d = '0;
    if (v_d) out_z_d = {sel, z[3 - sel]};
  end

  logic              out_valid_q;
  logic [D_SIZE-1:0] out_z_q;
  logic              v_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      v_q         <= 1'b0;
    end else begin
      out_valid_q <= stage_valid;
      if (stage_valid) begin
        out_z_q <= out_z_d;
        v_q     <= v_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign v         = v_q;

endmodule

// File: tb/tb_lzc_miao16.sv
// tb/tb_lzc_miao16.sv - directed vectors and exhaustive sweep for lzc_miao16
module tb_lzc_miao16;

`ifdef LZC_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in = 16'h0;
  logic        out_valid;
  logic [3:0]  out_z;
  logic        v;

  int n_chk = 0;
  int n_fail = 0;

  lzc_miao16 dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .out_valid(out_valid), .out_z(out_z), .v(v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [3:0]  ez;
    logic        ev;
  } vec_t;

  vec_t vecs [13];

  function automatic int lz_ref(input logic [15:0] x);
    int n = 0;
    for (int b = 15; b >= 0; b--) begin
      if (x[b]) break;
      n++;
    end
    return (n == 16) ? 0 : n;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic apply(input logic [15:0] d, input logic vl);
    @(negedge clk);
    in = d;
    in_valid = vl;
    repeat (LAT) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{16'h8000, 4'd0,  1'b1};
    vecs[1]  = '{16'h0001, 4'd15, 1'b1};
    vecs[2]  = '{16'h0002, 4'd14, 1'b1};
    vecs[3]  = '{16'h00FF, 4'd8,  1'b1};
    vecs[4]  = '{16'h0100, 4'd7,  1'b1};
    vecs[5]  = '{16'h1234, 4'd3,  1'b1};
    vecs[6]  = '{16'h7FFF, 4'd1,  1'b1};
    vecs[7]  = '{16'hFFFF, 4'd0,  1'b1};
    vecs[8]  = '{16'h0000, 4'd0,  1'b0};
    vecs[9]  = '{16'h0800, 4'd4,  1'b1};
    vecs[10] = '{16'h0080, 4'd8,  1'b1};
    vecs[11] = '{16'h0008, 4'd12, 1'b1};
    vecs[12] = '{16'h000F, 4'd12, 1'b1};

    // reset state
    in = 16'h1234;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_z", out_z, 0);
    chk("rst_v", v, 0);
    @(negedge clk);
    reset = 1'b1;

    // asynchronous reset mid-stream
    apply(16'h0001, 1'b1);
    chk("pre_rst_z", out_z, 15);
    chk("pre_rst_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_z", out_z, 0);
    chk("async_rst_v", v, 0);
    in = 16'h8000;
    @(negedge clk);
    reset = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("post_rst_z", out_z, 0);
    chk("post_rst_v", v, 1);
    chk("post_rst_valid", out_valid, 1);

    // directed table
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].din, 1'b1);
      chk($sformatf("vec%0d_z", i), out_z, vecs[i].ez);
      chk($sformatf("vec%0d_v", i), v, vecs[i].ev);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
    end

    // hold when in_valid drops
    apply(16'h00F0, 1'b1);
    chk("hold_pre_z", out_z, 8);
    apply(16'hFFFF, 1'b0);
    chk("hold_valid", out_valid, 0);
    chk("hold_z", out_z, 8);
    chk("hold_v", v, 1);

    // exhaustive streaming sweep, one sample per cycle
    for (int i = 0; i < 65535 + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_z !== 4'(lz_ref(16'(i - LAT + 1))) || v !== 1'b1) begin
          n_fail++;
          $display("FAIL sweep in=%h: got valid=%b z=%0d v=%b expected valid=1 z=%0d v=1",
                   16'(i - LAT + 1), out_valid, out_z, v, lz_ref(16'(i - LAT + 1)));
        end
      end
      if (i < 65535) begin
        in = 16'(i + 1);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("sweep_end_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lzc_miao16.md
Name: lzc_miao16

Overview:
- Registered 16-bit leading-zero counter built on Miao's hierarchical structure.
- Four 4-bit nibble leading-zero cells feed a boundary-nibble encoder and a 2-bit result mux.
- Used in the arithmetic-encoder range renormalisation path to find the shift amount of the 16-bit range value.
- Output carries the count plus a non-zero flag, one clock after the input is sampled.

Parameters:
- RANGE_WIDTH, 16, input width; fixed at 16 (structure is hard-wired for 4 nibbles)
- D_SIZE, 4, count width (log2 of RANGE_WIDTH)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  qualifies in for sampling
- in  input  16  value to count; bit 15 is MSB
- out_valid  output  1  out_z/v hold a new result
- out_z  output  4  leading-zero count of sampled in
- v  output  1  1 when sampled in is non-zero (out_z meaningful)

Behaviour:
- Nibble cells: in split into n3=in[15:12], n2=in[11:8], n1=in[7:4], n0=in[3:0].
  - Each cell i outputs a_i = (n_i == 0).
  - Each cell also outputs z_i[1:0] = leading zeros of n_i: 1xxx→0, 01xx→1, 001x→2, 0001→3, 0000→3.
- Boundary encoder: finds the first nibble from n3 down with a_i=0 and forms out_z[3:2]: n3→0, n2→1, n1→2, n0→3.
- Result mux: out_z[1:0] = z of that selected nibble.
- Zero input:
  - v = ~(a3&a2&a1&a0).
  - When v=0, out_z forced to 4'd0 (defined value, not don't-care).
- Required mapping: out_z = number of consecutive zero bits starting at bit 15, range 0..15 for non-zero inputs.
  - Examples: 0x8000→0, 0x0001→15, 0x00FF→8, 0x1234→3.
- Pipeline:
  - One register stage; no combinational path from in to outputs.
  - On rising clk with in_valid=1: out_z, v register the combinational result; out_valid←1.
  - On rising clk with in_valid=0: out_valid←0; out_z and v hold their previous values.
  - Latency 1 cycle; throughput 1 result per cycle; no backpressure.
- Reset:
  - reset=0 asynchronously clears out_z=0, v=0, out_valid=0.
  - Reset mid-stream discards any in-flight sample.
  - First sample is taken on the first rising edge after reset deasserts.
- No internal state other than the output registers.
- X-free: all 65536 input codes decode deterministically.

Optional Feature:
- Macro LZC_IN_REG_EN.
- Defined: adds an input register stage (in, in_valid) ahead of the nibble cells.
  - Latency becomes 2 cycles.
  - Input registers also clear asynchronously to 0 on reset=0.
  - Results are unchanged, only delayed one extra cycle.
- Undefined: single output register stage, latency 1 cycle, as above.

Test Plan:
- Reset: assert reset=0 mid-operation → out_z=0, v=0, out_valid=0 immediately (asynchronously); release, drive in=0x8000, in_valid=1 → next cycle out_z=0, v=1, out_valid=1.
- Exhaustive sweep in=1..65535, one per cycle, in_valid=1 → each result one cycle later equals leading_zero(in).
  - Spot values: 0x0001→15, 0x0002→14, 0x00FF→8, 0x0100→7, 0x1234→3, 0x7FFF→1, 0xFFFF→0.
- Zero input: in=0x0000, in_valid=1 → out_z=0, v=0, out_valid=1.
- Nibble boundaries: in=0x0800→4, 0x0080→8, 0x0008→12, 0x000F→12 → all v=1.
- Hold: result for 0x00F0 (out_z=8), then in_valid=0 with in=0xFFFF → out_valid=0, out_z stays 8, v stays 1.
- With LZC_IN_REG_EN defined, repeat the sweep → identical values at 2-cycle latency.
